// File: rtl/guess_scheduler.sv
// Two-player letter-guess scheduler: round-robin arbitration, guess validation,
// engine handshake with watchdog, and reveal/mistake bookkeeping.
module guess_scheduler #(
  parameter int MAX_MISS = 6,
  parameter int WD_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic [1:0] req,
  input  logic [7:0] guess0,
  input  logic [7:0] guess1,
  output logic [1:0] gnt,
  output logic       reject,
  output logic       eng_start,
  output logic [7:0] eng_guess,
  input  logic       eng_done,
  input  logic [4:0] eng_hit,
  output logic [4:0] revealed,
  output logic [2:0] miss_cnt,
  output logic       hit_p,
  output logic       miss_p,
  output logic       eng_err,
  output logic       turn,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISS);
  localparam logic [7:0] WD_LAST    = 8'(WD_LIMIT - 1);

  // One-hot bitmap position of an uppercase letter (caller guarantees legality)
  function automatic logic [25:0] letter_mask(input logic [7:0] g);
    logic [7:0] off;
    off = g - 8'h41;
    return 26'd1 << off[4:0];
  endfunction

  function automatic logic letter_legal(input logic [7:0] g);
    return (g >= 8'h41) && (g <= 8'h5A);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        reject_q, reject_d;
  logic        eng_start_q, eng_start_d;
  logic [7:0]  guess_q, guess_d;
  logic [4:0]  hit_q, hit_d;
  logic [4:0]  revealed_q, revealed_d;
  logic [2:0]  miss_cnt_q, miss_cnt_d;
  logic        hit_p_q, hit_p_d;
  logic        miss_p_q, miss_p_d;
  logic        eng_err_q, eng_err_d;
  logic        turn_q, turn_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;
  logic [25:0] bitmap_q, bitmap_d;
  logic [7:0]  wd_q, wd_d;
  logic        pick_s;
  logic [4:0]  rev_next_s;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = 2'b00;
    reject_d    = 1'b0;
    eng_start_d = 1'b0;
    hit_p_d     = 1'b0;
    miss_p_d    = 1'b0;
    eng_err_d   = 1'b0;
    guess_d     = guess_q;
    hit_d       = hit_q;
    revealed_d  = revealed_q;
    miss_cnt_d  = miss_cnt_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    bitmap_d    = bitmap_q;
    wd_d        = wd_q;
    pick_s      = 1'b0;
    rev_next_s  = revealed_q | hit_q;

    case (state_q)
      IDLE, OVER: begin
        if (new_game) begin
          state_d     = ARB;
          revealed_d  = 5'd0;
          miss_cnt_d  = 3'd0;
          bitmap_d    = 26'd0;
          game_over_d = 1'b0;
          win_d       = 1'b0;
          turn_d      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ARB: begin
        // A non-zero gnt_q marks the validation cycle of the guess just granted
        if (gnt_q != 2'b00) begin
          if (!letter_legal(guess_q) || ((bitmap_q & letter_mask(guess_q)) != 26'd0)) begin
            reject_d = 1'b1;
          end else begin
            bitmap_d    = bitmap_q | letter_mask(guess_q);
            eng_start_d = 1'b1;
            state_d     = ISSUE;
          end
        end else if (req != 2'b00) begin
          pick_s  = (req == 2'b11) ? ~turn_q : req[1];
          gnt_d   = pick_s ? 2'b10 : 2'b01;
          guess_d = pick_s ? guess1 : guess0;
          turn_d  = pick_s;
        end else begin
          state_d = ARB;
        end
      end
      ISSUE: begin
        wd_d    = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          hit_d   = eng_hit;
          state_d = UPDATE;
        end else if (wd_q == WD_LAST) begin
          eng_err_d = 1'b1;
          bitmap_d  = bitmap_q & ~letter_mask(guess_q);
          state_d   = ARB;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      UPDATE: begin
        revealed_d = rev_next_s;
        if (hit_q != 5'd0) begin
          hit_p_d = 1'b1;
        end else begin
          miss_p_d   = 1'b1;
          miss_cnt_d = miss_cnt_q + 3'd1;
        end
        if (rev_next_s == 5'b11111) begin
          win_d       = 1'b1;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else if (miss_cnt_d == MISS_LIMIT) begin
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          state_d = ARB;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      reject_q    <= 1'b0;
      eng_start_q <= 1'b0;
      guess_q     <= 8'd0;
      hit_q       <= 5'd0;
      revealed_q  <= 5'd0;
      miss_cnt_q  <= 3'd0;
      hit_p_q     <= 1'b0;
      miss_p_q    <= 1'b0;
      eng_err_q   <= 1'b0;
      turn_q      <= 1'b1;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      bitmap_q    <= 26'd0;
      wd_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      reject_q    <= reject_d;
      eng_start_q <= eng_start_d;
      guess_q     <= guess_d;
      hit_q       <= hit_d;
      revealed_q  <= revealed_d;
      miss_cnt_q  <= miss_cnt_d;
      hit_p_q     <= hit_p_d;
      miss_p_q    <= miss_p_d;
      eng_err_q   <= eng_err_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
      bitmap_q    <= bitmap_d;
      wd_q        <= wd_d;
    end
  end

  assign gnt       = gnt_q;
  assign reject    = reject_q;
  assign eng_start = eng_start_q;
  assign eng_guess = guess_q;
  assign revealed  = revealed_q;
  assign miss_cnt  = miss_cnt_q;
  assign hit_p     = hit_p_q;
  assign miss_p    = miss_p_q;
  assign eng_err   = eng_err_q;
  assign turn      = turn_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: tb/tb_guess_scheduler.sv
// Directed self-checking bench for guess_scheduler (MAX_MISS=6, WD_LIMIT=4).
module tb_guess_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] guess0 = 8'd0;
  logic [7:0] guess1 = 8'd0;
  logic       eng_done = 1'b0;
  logic [4:0] eng_hit = 5'd0;
  logic [1:0] gnt;
  logic       reject, eng_start, hit_p, miss_p, eng_err, turn, game_over, win;
  logic [7:0] eng_guess;
  logic [4:0] revealed;
  logic [2:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  logic [25:0] tb_bitmap;
  logic [4:0]  exp_rev;
  logic [2:0]  exp_miss;
  logic        exp_over, exp_win;

  guess_scheduler #(.MAX_MISS(6), .WD_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .req(req),
    .guess0(guess0), .guess1(guess1), .gnt(gnt), .reject(reject),
    .eng_start(eng_start), .eng_guess(eng_guess), .eng_done(eng_done),
    .eng_hit(eng_hit), .revealed(revealed), .miss_cnt(miss_cnt),
    .hit_p(hit_p), .miss_p(miss_p), .eng_err(eng_err), .turn(turn),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    tb_bitmap = 26'd0;
    exp_rev   = 5'd0;
    exp_miss  = 3'd0;
    exp_over  = 1'b0;
    exp_win   = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
  endtask

  // One full request: grant, validation, and (if valid) engine round trip
  task automatic play(input logic [1:0] r, input logic [7:0] g0, input logic [7:0] g1,
                      input logic [1:0] exp_gnt, input logic [4:0] hit);
    logic [7:0] g;
    logic       valid;
    int         idx;
    guess0 = g0;
    guess1 = g1;
    req = r;
    tick();
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    g = exp_gnt[1] ? g1 : g0;
    check_eq("turn", 32'(turn), 32'(exp_gnt[1]));
    req = 2'b00;
    tick();
    valid = 1'b0;
    idx = 0;
    if ((g >= 8'h41) && (g <= 8'h5A)) begin
      idx = int'(g) - 65;
      valid = !tb_bitmap[idx];
    end
    if (!valid) begin
      check_eq("reject", 32'(reject), 32'd1);
      check_eq("no_eng_start", 32'(eng_start), 32'd0);
      check_eq("miss_cnt_rej", 32'(miss_cnt), 32'(exp_miss));
    end else begin
      tb_bitmap[idx] = 1'b1;
      check_eq("no_reject", 32'(reject), 32'd0);
      check_eq("eng_start", 32'(eng_start), 32'd1);
      check_eq("eng_guess", 32'(eng_guess), 32'(g));
      tick();
      check_eq("eng_start_1cyc", 32'(eng_start), 32'd0);
      eng_done = 1'b1;
      eng_hit = hit;
      tick();
      eng_done = 1'b0;
      eng_hit = 5'd0;
      check_eq("eng_guess_hold", 32'(eng_guess), 32'(g));
      tick();
      exp_rev = exp_rev | hit;
      if (hit == 5'd0) exp_miss = exp_miss + 3'd1;
      if (exp_rev == 5'b11111) begin
        exp_over = 1'b1;
        exp_win = 1'b1;
      end else if (exp_miss == 3'd6) begin
        exp_over = 1'b1;
      end
      check_eq("hit_p", 32'(hit_p), 32'(hit != 5'd0));
      check_eq("miss_p", 32'(miss_p), 32'(hit == 5'd0));
      check_eq("revealed", 32'(revealed), 32'(exp_rev));
      check_eq("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
      check_eq("game_over", 32'(game_over), 32'(exp_over));
      check_eq("win", 32'(win), 32'(exp_win));
    end
  endtask

  initial begin
    model_clear();
    // Reset state
    tick();
    tick();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_eng_start", 32'(eng_start), 32'd0);
    check_eq("rst_eng_guess", 32'(eng_guess), 32'd0);
    check_eq("rst_revealed", 32'(revealed), 32'd0);
    check_eq("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check_eq("rst_turn", 32'(turn), 32'd1);
    check_eq("rst_game_over", 32'(game_over), 32'd0);

    // Single hit on 'A' by player 0
    restart();
    play(2'b01, 8'h41, 8'h00, 2'b01, 5'b10000);

    // Both requesting: grants alternate starting with player 0
    restart();
    play(2'b11, 8'h42, 8'h43, 2'b01, 5'b00000);
    play(2'b11, 8'h44, 8'h45, 2'b10, 5'b00000);
    play(2'b11, 8'h46, 8'h47, 2'b01, 5'b00000);
    play(2'b11, 8'h48, 8'h49, 2'b10, 5'b00000);

    // Duplicate and lowercase guesses are rejected
    restart();
    play(2'b01, 8'h41, 8'h00, 2'b01, 5'b00001);
    play(2'b10, 8'h00, 8'h41, 2'b10, 5'b00000);
    play(2'b01, 8'h61, 8'h00, 2'b01, 5'b00000);
    check_eq("miss_after_rej", 32'(miss_cnt), 32'd0);

    // Six misses end the game as a loss; no grants afterwards
    restart();
    play(2'b01, 8'h42, 8'h00, 2'b01, 5'b00000);
    play(2'b01, 8'h43, 8'h00, 2'b01, 5'b00000);
    play(2'b01, 8'h44, 8'h00, 2'b01, 5'b00000);
    play(2'b01, 8'h45, 8'h00, 2'b01, 5'b00000);
    play(2'b01, 8'h46, 8'h00, 2'b01, 5'b00000);
    play(2'b01, 8'h47, 8'h00, 2'b01, 5'b00000);
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("over_no_gnt", 32'(gnt), 32'd0);
      check_eq("over_hold", 32'(game_over), 32'd1);
    end
    req = 2'b00;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    check_eq("ng_game_over", 32'(game_over), 32'd0);
    check_eq("ng_miss_cnt", 32'(miss_cnt), 32'd0);
    check_eq("ng_turn", 32'(turn), 32'd1);

    // Five misses, then hits completing the word: win beats loss
    play(2'b10, 8'h00, 8'h42, 2'b10, 5'b00000);
    play(2'b10, 8'h00, 8'h43, 2'b10, 5'b00000);
    play(2'b10, 8'h00, 8'h44, 2'b10, 5'b00000);
    play(2'b10, 8'h00, 8'h45, 2'b10, 5'b00000);
    play(2'b10, 8'h00, 8'h46, 2'b10, 5'b00000);
    play(2'b10, 8'h00, 8'h47, 2'b10, 5'b01111);
    play(2'b10, 8'h00, 8'h48, 2'b10, 5'b10000);

    // Watchdog: engine never answers
    restart();
    guess0 = 8'h4B;
    req = 2'b01;
    tick();
    check_eq("wd_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    tick();
    check_eq("wd_eng_start", 32'(eng_start), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wd_no_err_early", 32'(eng_err), 32'd0);
    end
    tick();
    check_eq("wd_eng_err", 32'(eng_err), 32'd1);
    check_eq("wd_miss_cnt", 32'(miss_cnt), 32'd0);
    tick();
    check_eq("wd_err_pulse", 32'(eng_err), 32'd0);
    play(2'b01, 8'h4B, 8'h00, 2'b01, 5'b00100);

    // Reset while waiting on the engine; late eng_done ignored
    restart();
    guess0 = 8'h4C;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("wrst_eng_guess", 32'(eng_guess), 32'd0);
    check_eq("wrst_gnt", 32'(gnt), 32'd0);
    check_eq("wrst_turn", 32'(turn), 32'd1);
    eng_done = 1'b1;
    eng_hit = 5'b11111;
    tick();
    eng_done = 1'b0;
    eng_hit = 5'd0;
    tick();
    check_eq("late_done_revealed", 32'(revealed), 32'd0);
    check_eq("late_done_hit_p", 32'(hit_p), 32'd0);
    check_eq("late_done_win", 32'(win), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_scheduler.md
GUESS_SCHEDULER -- requirements
Module: guess_scheduler

Interface
REQ-001 SHALL have parameter: MAX_MISS, 6, mistake count that ends the game as a loss (range 1-7).
REQ-002 SHALL have parameter: WD_LIMIT, 255, cycles to wait for eng_done before abandoning a guess (range 1-255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- new_game  in  1  pulse: clear state, start a round
- req  in  2  per-player guess request, held until gnt
- guess0, guess1  in  8 each  ASCII guess of player 0 / player 1
- gnt  out  2  one-hot 1-cycle acceptance pulse
- reject  out  1  1-cycle pulse: granted guess invalid or duplicate
- eng_start  out  1  1-cycle pulse to the letter-compare engine
- eng_guess  out  8  guess presented to the engine
- eng_done  in  1  engine result-valid pulse
- eng_hit  in  5  per-position match mask, valid with eng_done
- revealed  out  5  accumulated matched positions
- miss_cnt  out  3  mistakes so far
- hit_p, miss_p  out  1 each  1-cycle result pulses
- eng_err  out  1  1-cycle watchdog-expiry pulse
- turn  out  1  last granted player
- game_over, win  out  1 each  level: round ended; ended by full reveal

Function
REQ-005 SHALL implement states IDLE, ARB, ISSUE, WAIT, UPDATE, OVER.
REQ-006 SHALL leave IDLE or OVER for ARB one cycle after new_game=1, clearing revealed, miss_cnt, letter bitmap, game_over, win, and setting turn=1; new_game is ignored in all other states.
REQ-007 SHALL in ARB, when req!=0, grant round-robin: with both requesting, grant the player other than turn; with one requesting, grant it; set gnt (registered, next cycle), latch that player's guess, update turn.
REQ-008 SHALL, in the gnt cycle, validate the latched guess: only 0x41-0x5A is legal; illegal or already-set in the 26-bit guessed bitmap -> reject pulse in the following cycle, return to ARB, no engine activity, no counter change.
REQ-009 SHALL for a legal new guess set its bitmap bit, enter ISSUE, drive eng_start=1 for exactly one cycle with eng_guess stable from ISSUE until UPDATE completes.
REQ-010 SHALL in WAIT sample eng_hit on eng_done=1 and enter UPDATE; eng_done outside WAIT is ignored.
REQ-011 SHALL in UPDATE: revealed <= revealed | eng_hit; eng_hit!=0 -> hit_p=1; eng_hit==0 -> miss_p=1, miss_cnt+1.
REQ-012 SHALL go from UPDATE to OVER with win=1 if the new revealed==5'b11111, else to OVER with win=0 if the new miss_cnt==MAX_MISS, else to ARB; win takes priority.
REQ-013 SHALL count WAIT cycles; reaching WD_LIMIT without eng_done pulses eng_err, clears the guessed bit for that letter, returns to ARB, no counter change.
REQ-014 SHALL hold game_over=1 throughout OVER, ignore req, and produce no gnt.
REQ-015 SHALL latency from req (in ARB) to gnt = 1 cycle, gnt to eng_start = 1 cycle; min ARB-to-ARB turnaround 4 cycles + engine latency.

Reset
REQ-016 SHALL on rst=1 at a clock edge, from any state including mid-WAIT, enter IDLE with all outputs 0, turn=1, bitmap/counters/watchdog cleared; rst has priority over new_game.

Verification
REQ-017 SHALL cover: new_game, req=01 guess0=0x41, engine returns eng_hit=10000 -> gnt=01, eng_start one cycle with eng_guess=0x41, hit_p, revealed=10000.
REQ-018 SHALL cover: req=11 repeatedly after new_game -> grants alternate 01,10,01,10, first grant player 0.
REQ-019 SHALL cover: guess 0x41 twice, then 0x61 -> second and third each give reject, no eng_start, miss_cnt unchanged.
REQ-020 SHALL cover: six distinct misses (eng_hit=0) -> miss_cnt=6, game_over=1, win=0; further req gets no gnt.
REQ-021 SHALL cover: hits covering all five positions -> game_over=1, win=1 same UPDATE even if miss_cnt=5; engine never answers with WD_LIMIT=4 -> eng_err after 4 WAIT cycles, letter guessable again.
REQ-022 SHALL cover: rst asserted in WAIT -> next cycle IDLE, all outputs 0; late eng_done ignored.
